branch_flush_ctrl: RTL
======================

BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; asserted (0) forces the reset state immediately, independent of clk.
REQ-003 ex_branch  input  1  EX-stage instruction is a conditional branch.
REQ-004 ex_funct3  input  3  branch condition code: 3'b011 beq, 3'b101 bne, 3'b111 bge.
REQ-005 ex_zero  input  1  ALU zero flag for the EX-stage instruction.
REQ-006 ex_a, ex_b  input  64 each  branch operands.
REQ-007 ex_target  input  64  computed branch target address.
REQ-008 idex_mem_read  input  1  EX-stage instruction is a load.
REQ-009 idex_rd  input  5  destination register of the EX-stage instruction.
REQ-010 ifid_rs1, ifid_rs2  input  5 each  source registers of the ID-stage instruction.
REQ-011 pc_src  output  1  1 = PC loads pc_target on the next edge.
REQ-012 pc_target  output  64  registered redirect address.
REQ-013 flush_ifid, flush_idex  output  1 each  zero the IF/ID and ID/EX pipeline registers.
REQ-014 stall_pc, stall_ifid  output  1 each  hold the PC and the IF/ID register.
REQ-015 bubble_idex  output  1  insert a NOP into ID/EX.
REQ-016 branch_cnt, taken_cnt  output  16 each  saturating counts of resolved and taken branches.
REQ-017 state  output  2  current FSM state, for debug.

Function
REQ-018 Taken condition (combinational): ex_branch AND one of the following:
- funct3 = 011 and ex_zero = 1
- funct3 = 101 and ex_zero = 0
- funct3 = 111 and ex_a >= ex_b, compared unsigned over 64 bits
REQ-019 Any other funct3 with ex_branch = 1 is not taken, but it still counts as a resolved branch.
REQ-020 Load-use hazard (combinational): idex_mem_read = 1, idex_rd != 0, and idex_rd equals ifid_rs1 or ifid_rs2.
REQ-021 FSM states: RUN = 2'b00, FLUSH = 2'b01, STALL = 2'b10. Encoding 2'b11 is illegal and returns to RUN on the next edge with all outputs inactive.
REQ-022 RUN transitions:
- taken -> FLUSH; pc_target is latched from ex_target on the same edge.
- else load-use hazard -> STALL.
- else stay in RUN.
REQ-023 Taken has priority over load-use when both occur in the same cycle; the stall is dropped because the dependent instruction is flushed.
REQ-024 FLUSH lasts exactly one cycle; outputs pc_src = 1, flush_ifid = 1, flush_idex = 1. The next state is RUN unconditionally.
REQ-025 Branch and hazard inputs are ignored during FLUSH (shadow instruction); counters do not increment.
REQ-026 STALL lasts exactly one cycle; outputs stall_pc = 1, stall_ifid = 1, bubble_idex = 1. The next state is RUN.
REQ-027 Branch evaluation is ignored during STALL, because EX holds the inserted bubble.
REQ-028 All control outputs are decoded from the registered state only, with no combinational path from inputs. Latency from the taken evaluation edge to pc_src is 1 cycle.
REQ-029 In RUN all control outputs are 0. pc_target holds its last latched value.
REQ-030 Counters (in RUN only):
- branch_cnt increments on each edge where ex_branch = 1.
- taken_cnt increments on each edge where taken = 1.
- Both saturate at 16'hFFFF; no wrap.
REQ-031 Back-to-back taken branches: the second branch, arriving during FLUSH, is ignored by design. The pipeline guarantees it is a flushed instruction.

Reset
REQ-032 While reset = 0:
- state = RUN
- pc_src, flush_ifid, flush_idex, stall_pc, stall_ifid, bubble_idex = 0
- pc_target = 64'h0
- branch_cnt = taken_cnt = 0
REQ-033 Reset asserted during FLUSH or STALL aborts the operation immediately. Outputs go to their reset values without waiting for clk.
REQ-034 After reset deasserts, the first evaluation occurs on the next rising clk edge.

Verification
REQ-035 beq with ex_zero = 1 and ex_target = 64'h40 in RUN -> next cycle pc_src = 1, pc_target = 64'h40, flush_ifid = flush_idex = 1; following cycle all outputs 0; taken_cnt = 1, branch_cnt = 1.
REQ-036 bne with ex_zero = 1 -> no flush; branch_cnt = 1, taken_cnt = 0. bge with ex_a = 5, ex_b = 5 -> taken. bge with ex_a = 3, ex_b = 64'hFFFF_FFFF_FFFF_FFFF -> not taken (unsigned).
REQ-037 Load with idex_rd = 7 and ifid_rs2 = 7 -> one cycle of stall_pc = stall_ifid = bubble_idex = 1, then RUN. idex_rd = 0 -> no stall.
REQ-038 Taken beq and load-use hazard in the same cycle -> FLUSH only, no STALL cycle.
REQ-039 Assert reset mid-FLUSH (between edges) -> pc_src and flush outputs drop to 0 immediately; state = RUN.
REQ-040 Preload counters near saturation (65535 taken branches) -> taken_cnt stays at 16'hFFFF on the next taken branch.

Source files
------------

// File: rtl/branch_flush_ctrl.sv
// Branch resolution and hazard control: redirects the PC on taken branches,
// flushes the shadow instruction, and stalls one cycle on load-use hazards.
module branch_flush_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_branch,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_zero,
    input  logic [63:0] ex_a,
    input  logic [63:0] ex_b,
    input  logic [63:0] ex_target,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    output logic        pc_src,
    output logic [63:0] pc_target,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        bubble_idex,
    output logic [15:0] branch_cnt,
    output logic [15:0] taken_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        FLUSH   = 2'b01,
        STALL   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t      st;
    logic        taken;
    logic        hazard;
    logic [15:0] bcnt;
    logic [15:0] tcnt;

    always_comb begin
        taken = 1'b0;
        if (ex_branch) begin
            case (ex_funct3)
                3'b011:  taken = ex_zero;
                3'b101:  taken = ~ex_zero;
                3'b111:  taken = (ex_a >= ex_b);
                default: taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        hazard = idex_mem_read && (idex_rd != 5'd0) &&
                 ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    end

    // Control outputs are registered together with the next state, so they
    // always reflect the current state register and never the live inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= RUN;
            pc_src      <= 1'b0;
            pc_target   <= '0;
            flush_ifid  <= 1'b0;
            flush_idex  <= 1'b0;
            stall_pc    <= 1'b0;
            stall_ifid  <= 1'b0;
            bubble_idex <= 1'b0;
            bcnt        <= '0;
            tcnt        <= '0;
        end else begin
            pc_src      <= 1'b0;
            flush_ifid  <= 1'b0;
            flush_idex  <= 1'b0;
            stall_pc    <= 1'b0;
            stall_ifid  <= 1'b0;
            bubble_idex <= 1'b0;
            case (st)
                RUN: begin
                    if (taken) begin
                        st         <= FLUSH;
                        pc_target  <= ex_target;
                        pc_src     <= 1'b1;
                        flush_ifid <= 1'b1;
                        flush_idex <= 1'b1;
                    end else if (hazard) begin
                        st          <= STALL;
                        stall_pc    <= 1'b1;
                        stall_ifid  <= 1'b1;
                        bubble_idex <= 1'b1;
                    end else begin
                        st <= RUN;
                    end
                    if (ex_branch)
                        bcnt <= (bcnt == '1) ? bcnt : bcnt + 16'd1;
                    if (taken)
                        tcnt <= (tcnt == '1) ? tcnt : tcnt + 16'd1;
                end
                default: st <= RUN;
            endcase
        end
    end

    assign branch_cnt = bcnt;
    assign taken_cnt  = tcnt;
    assign state      = st;

endmodule
